// File: rtl/dds_pkg.sv
// Shared constants and wave-select encoding for the DDS voice path.
package dds_pkg;

  localparam int unsigned DDS_ADDR_W = 10;
  localparam int unsigned DDS_DATA_W = 24;
  localparam logic [DDS_DATA_W-1:0] MIDSCALE = DDS_DATA_W'(1) << (DDS_DATA_W - 1);

  typedef enum logic [2:0] {
    SINE    = 3'd0,
    POS_SAW = 3'd1,
    NEG_SAW = 3'd2,
    TRI     = 3'd3,
    SQ      = 3'd4
  } wave_sel_e;

endpackage

// File: rtl/tri_fold.sv
// Folds a phase address into a symmetric ramp: rises over the first half, mirrors over the second.
module tri_fold #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] address_i,
  output logic [ADDR_W-2:0] ramp_o
);

  always_comb begin
    ramp_o = address_i[ADDR_W-1] ? ~address_i[ADDR_W-2:0] : address_i[ADDR_W-2:0];
  end

endmodule

// File: rtl/wavetable_basic_shapes.sv
// Arithmetic square / triangle / falling-saw tables with one registered output stage.
module wavetable_basic_shapes
  import dds_pkg::*;
#(
  parameter int unsigned ADDR_W = DDS_ADDR_W,
  parameter int unsigned DATA_W = DDS_DATA_W  // must exceed ADDR_W
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] q_sq,
  output logic [DATA_W-1:0] q_tri,
  output logic [DATA_W-1:0] q_nsaw
);

  localparam int unsigned SH = DATA_W - ADDR_W;

  function automatic logic [DATA_W-1:0] sq_shape(input logic msb);
    return msb ? '0 : '1;
  endfunction

  // Widen before shifting so the scaled value cannot lose bits.
  function automatic logic [DATA_W-1:0] tri_shape(input logic [ADDR_W-2:0] ramp);
    return DATA_W'(ramp) << (SH + 1);
  endfunction

  function automatic logic [DATA_W-1:0] nsaw_shape(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] inv;
    inv = ~addr;  // equals 2^ADDR_W-1-addr
    return DATA_W'(inv) << SH;
  endfunction

  logic [ADDR_W-2:0] ramp;

  logic [DATA_W-1:0] q_sq_d, q_sq_q;
  logic [DATA_W-1:0] q_tri_d, q_tri_q;
  logic [DATA_W-1:0] q_nsaw_d, q_nsaw_q;

  tri_fold #(
    .ADDR_W (ADDR_W)
  ) u_tri_fold (
    .address_i (address),
    .ramp_o    (ramp)
  );

  always_comb begin
    q_sq_d   = sq_shape(address[ADDR_W-1]);
    q_tri_d  = tri_shape(ramp);
    q_nsaw_d = nsaw_shape(address);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      q_sq_q   <= '0;
      q_tri_q  <= '0;
      q_nsaw_q <= '0;
    end else begin
      q_sq_q   <= q_sq_d;
      q_tri_q  <= q_tri_d;
      q_nsaw_q <= q_nsaw_d;
    end
  end

  assign q_sq   = q_sq_q;
  assign q_tri  = q_tri_q;
  assign q_nsaw = q_nsaw_q;

endmodule

// File: tb/tb_wavetable_basic_shapes.sv
// Self-checking bench for wavetable_basic_shapes with ADDR_W=10, DATA_W=24.
module tb_wavetable_basic_shapes;

  typedef struct {
    logic [23:0] sq;
    logic [23:0] tri_s;
    logic [23:0] nsaw;
  } exp_t;

  typedef struct {
    logic [9:0]  addr;
    logic [23:0] sq;
    logic [23:0] tri_s;
    logic [23:0] nsaw;
    string       nm;
  } vec_t;

  logic        clk;
  logic        nreset;
  logic [9:0]  address;
  logic [23:0] q_sq, q_tri, q_nsaw;

  int   n_vec;
  int   n_fail;
  exp_t sb[$];
  exp_t last_exp;

  wavetable_basic_shapes #(
    .ADDR_W (10),
    .DATA_W (24)
  ) dut (
    .clk     (clk),
    .nreset  (nreset),
    .address (address),
    .q_sq    (q_sq),
    .q_tri   (q_tri),
    .q_nsaw  (q_nsaw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%06h, required 0x%06h", nm, act, exp);
    end
  endtask

  task automatic check_bit(input string nm, input bit ok);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got property false, required true", nm);
    end
  endtask

  // Independent reference written directly from the sample-value definitions.
  function automatic exp_t model(input int a);
    exp_t e;
    e.sq    = (a < 512) ? 24'hFFFFFF : 24'h000000;
    e.tri_s = (a < 512) ? 24'(a * 32768) : 24'((1023 - a) * 32768);
    e.nsaw  = 24'((1023 - a) * 16384);
    return e;
  endfunction

  // Starts at a negedge: drive, confirm outputs still hold, then score after the edge.
  task automatic step(input logic [9:0] a, input exp_t e, input string nm);
    exp_t got;
    address = a;
    #1;
    check({nm, "_hold_nsaw"}, q_nsaw, last_exp.nsaw);
    check({nm, "_hold_tri"}, q_tri, last_exp.tri_s);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_bit({nm, "_scoreboard_empty"}, 1'b0);
    end else begin
      got = sb.pop_front();
      check({nm, "_sq"}, q_sq, got.sq);
      check({nm, "_tri"}, q_tri, got.tri_s);
      check({nm, "_nsaw"}, q_nsaw, got.nsaw);
      last_exp = got;
    end
    @(negedge clk);
  endtask

  vec_t vecs[9];

  initial begin
    exp_t e;
    logic [23:0] p_sq, p_tri, p_nsaw;
    int toggles;
    int toggle_at;
    n_vec  = 0;
    n_fail = 0;

    vecs[0] = '{10'd0,    24'hFFFFFF, 24'h000000, 24'hFFC000, "addr0"};
    vecs[1] = '{10'd511,  24'hFFFFFF, 24'hFF8000, 24'h800000, "addr511"};
    vecs[2] = '{10'd512,  24'h000000, 24'hFF8000, 24'h7FC000, "addr512"};
    vecs[3] = '{10'd1023, 24'h000000, 24'h000000, 24'h000000, "addr1023"};
    vecs[4] = '{10'd0,    24'hFFFFFF, 24'h000000, 24'hFFC000, "wrap0"};
    vecs[5] = '{10'd100,  24'hFFFFFF, 24'h320000, 24'hE6C000, "lat100"};
    vecs[6] = '{10'd200,  24'hFFFFFF, 24'h640000, 24'hCDC000, "lat200"};
    vecs[7] = '{10'd300,  24'hFFFFFF, 24'h960000, 24'hB4C000, "lat300"};
    vecs[8] = '{10'd768,  24'h000000, 24'h7F8000, 24'h3FC000, "addr768"};

    // Reset held with a non-zero address.
    nreset   = 1'b0;
    address  = 10'd300;
    last_exp = '{24'h0, 24'h0, 24'h0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sq", q_sq, 24'h0);
    check("rst_tri", q_tri, 24'h0);
    check("rst_nsaw", q_nsaw, 24'h0);
    nreset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      e.sq    = vecs[i].sq;
      e.tri_s = vecs[i].tri_s;
      e.nsaw  = vecs[i].nsaw;
      step(vecs[i].addr, e, vecs[i].nm);
    end

    // Full-period sweep with shape properties.
    toggles   = 0;
    toggle_at = -1;
    p_sq = 24'h0; p_tri = 24'h0; p_nsaw = 24'h0;
    for (int a = 0; a < 1024; a++) begin
      step(10'(a), model(a), $sformatf("sweep%0d", a));
      if (a > 0) begin
        check_bit($sformatf("nsaw_dec%0d", a), q_nsaw < p_nsaw);
        if (a <= 511) check_bit($sformatf("tri_inc%0d", a), q_tri > p_tri);
        if (a >= 513) check_bit($sformatf("tri_dec%0d", a), q_tri < p_tri);
        if (q_sq != p_sq) begin
          toggles++;
          toggle_at = a;
        end
      end
      p_sq = q_sq; p_tri = q_tri; p_nsaw = q_nsaw;
    end
    check("sq_toggle_count", 24'(toggles), 24'd1);
    check("sq_toggle_addr", 24'(toggle_at), 24'd512);

    // Asynchronous reset between edges mid-sweep.
    for (int a = 0; a < 200; a++) begin
      step(10'(a), model(a), $sformatf("rs%0d", a));
      if (a == 150) begin
        #2;
        nreset = 1'b0;
        #1;
        check("async_rst_sq", q_sq, 24'h0);
        check("async_rst_tri", q_tri, 24'h0);
        check("async_rst_nsaw", q_nsaw, 24'h0);
        repeat (2) begin
          @(posedge clk);
          #1;
          check("rst_held_sq", q_sq, 24'h0);
          check("rst_held_nsaw", q_nsaw, 24'h0);
        end
        @(negedge clk);
        nreset = 1'b1;
        sb.delete();
        last_exp = '{24'h0, 24'h0, 24'h0};
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
